// File: rtl/output_bram_pkg.sv
// Shared definitions for the output BRAM write-back path: scheduler state
// encoding, bank-index width and the bank/address mapping used by both sides.
package output_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  localparam int OUTPUT_BRAM_NUM_DFLT  = 4;
  localparam int OUTPUT_BANK_IDX_WIDTH = $clog2(OUTPUT_BRAM_NUM_DFLT);
  localparam int MAP_WIDTH             = 32;

  typedef struct packed {
    logic [MAP_WIDTH-1:0] bank;
    logic [MAP_WIDTH-1:0] addr;
  } bram_loc_t;

  // Channel offset d interleaves across banks; each bank group holds a full
  // row*col plane, so callers truncate the result to their address width.
  function automatic bram_loc_t bram_map(
    input logic [MAP_WIDTH-1:0] d,
    input logic [MAP_WIDTH-1:0] r,
    input logic [MAP_WIDTH-1:0] c,
    input logic [MAP_WIDTH-1:0] row,
    input logic [MAP_WIDTH-1:0] col,
    input int                   bank_bits
  );
    bram_loc_t            loc;
    logic [MAP_WIDTH-1:0] mask;
    mask     = (MAP_WIDTH'(1) << bank_bits) - MAP_WIDTH'(1);
    loc.bank = d & mask;
    loc.addr = (d >> bank_bits) * row * col + r * col + c;
    return loc;
  endfunction

endpackage

// File: rtl/output_bram_addr_gen.sv
// Combinational bank/address mapping for one output beat; the caller
// registers the results.
module output_bram_addr_gen
  import output_bram_pkg::*;
#(
  parameter int OUTPUT_CHANNEL_WIDTH      = 8,
  parameter int OUTPUT_ROW_WIDTH          = 6,
  parameter int OUTPUT_COL_WIDTH          = 6,
  parameter int OUTPUT_BRAM_NUM           = 4,
  parameter int OUTPUT_BRAM_ADDRESS_WIDTH = 11,
  parameter int BANK_W                    = 2
) (
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_d,
  input  logic [OUTPUT_ROW_WIDTH-1:0]          i_r,
  input  logic [OUTPUT_COL_WIDTH-1:0]          i_c,
  input  logic [OUTPUT_ROW_WIDTH-1:0]          i_row,
  input  logic [OUTPUT_COL_WIDTH-1:0]          i_col,
  output logic [BANK_W-1:0]                    o_bank,
  output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_addr
);

  localparam int BANK_BITS = $clog2(OUTPUT_BRAM_NUM);

  bram_loc_t loc;
  logic      unused_map_bits;

  always_comb begin
    loc = bram_map(MAP_WIDTH'(i_d), MAP_WIDTH'(i_r), MAP_WIDTH'(i_c),
                   MAP_WIDTH'(i_row), MAP_WIDTH'(i_col), BANK_BITS);
    o_bank = loc.bank[BANK_W-1:0];
    o_addr = loc.addr[OUTPUT_BRAM_ADDRESS_WIDTH-1:0];
    // Upper bits fall outside the bank array by construction.
    unused_map_bits = ^{loc.bank[MAP_WIDTH-1:BANK_W],
                        loc.addr[MAP_WIDTH-1:OUTPUT_BRAM_ADDRESS_WIDTH]};
  end

endmodule

// File: rtl/output_writeback_scheduler.sv
// Writes one output tile's PE result stream (channel, then column, then row)
// into the interleaved output BRAM banks and reports completion.
module output_writeback_scheduler
  import output_bram_pkg::*;
#(
  parameter int OUTPUT_CHANNEL_WIDTH      = 8,
  parameter int OUTPUT_ROW_WIDTH          = 6,
  parameter int OUTPUT_COL_WIDTH          = 6,
  parameter int OUTPUT_BRAM_NUM           = OUTPUT_BRAM_NUM_DFLT,
  parameter int OUTPUT_BRAM_DEPTH         = 1152,
  parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
  parameter int DATA_WIDTH                = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_channel_start,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_channel_end,
  input  logic [OUTPUT_ROW_WIDTH-1:0]          i_row,
  input  logic [OUTPUT_COL_WIDTH-1:0]          i_col,
  input  logic                                 i_data_valid,
  input  logic [DATA_WIDTH-1:0]                i_data,
  output logic                                 o_data_ready,
  output logic [OUTPUT_BRAM_NUM-1:0]           o_bram_we,
  output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0]                o_bram_wdata,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_cfg_err
);

  localparam int BANK_W = (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1;

  wb_state_e state_q, state_d;

  logic [OUTPUT_CHANNEL_WIDTH-1:0]      ch_start_q, ch_start_d;
  logic [OUTPUT_CHANNEL_WIDTH-1:0]      ch_end_q, ch_end_d;
  logic [OUTPUT_ROW_WIDTH-1:0]          row_q, row_d;
  logic [OUTPUT_COL_WIDTH-1:0]          col_q, col_d;
  logic                                 cfg_err_q, cfg_err_d;
  logic [OUTPUT_CHANNEL_WIDTH-1:0]      ch_q, ch_d;
  logic [OUTPUT_ROW_WIDTH-1:0]          r_q, r_d;
  logic [OUTPUT_COL_WIDTH-1:0]          c_q, c_d;
  logic [OUTPUT_BRAM_NUM-1:0]           bram_we_q, bram_we_d;
  logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]                bram_wdata_q, bram_wdata_d;

  logic                                 start_accept;
  logic                                 cfg_bad;
  logic                                 data_ready;
  logic                                 beat_accept;
  logic                                 ch_wrap;
  logic                                 c_wrap;
  logic                                 last_beat;
  logic [OUTPUT_CHANNEL_WIDTH-1:0]      ch_delta;
  logic [BANK_W-1:0]                    map_bank;
  logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] map_addr;

  assign start_accept = (state_q == ST_IDLE) && i_start;
  assign cfg_bad      = (i_row == '0) || (i_col == '0) ||
                        (i_channel_end < i_channel_start);
  assign beat_accept  = i_data_valid && data_ready;
  assign ch_wrap      = (ch_q == ch_end_q);
  assign c_wrap       = (c_q == col_q - 1'b1);
  assign last_beat    = ch_wrap && c_wrap && (r_q == row_q - 1'b1);
  assign ch_delta     = ch_q - ch_start_q;

  output_bram_addr_gen #(
    .OUTPUT_CHANNEL_WIDTH      (OUTPUT_CHANNEL_WIDTH),
    .OUTPUT_ROW_WIDTH          (OUTPUT_ROW_WIDTH),
    .OUTPUT_COL_WIDTH          (OUTPUT_COL_WIDTH),
    .OUTPUT_BRAM_NUM           (OUTPUT_BRAM_NUM),
    .OUTPUT_BRAM_ADDRESS_WIDTH (OUTPUT_BRAM_ADDRESS_WIDTH),
    .BANK_W                    (BANK_W)
  ) u_addr_gen (
    .i_d    (ch_delta),
    .i_r    (r_q),
    .i_c    (c_q),
    .i_row  (row_q),
    .i_col  (col_q),
    .o_bank (map_bank),
    .o_addr (map_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_start) state_d = cfg_bad ? ST_DONE : ST_RUN;
      ST_RUN:  if (beat_accept && last_beat) state_d = ST_LAST;
      ST_LAST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state_q == ST_RUN);
    o_busy     = (state_q != ST_IDLE);
    o_done     = (state_q == ST_DONE);
    o_cfg_err  = (state_q == ST_DONE) && cfg_err_q;
  end

  assign o_data_ready = data_ready;

  // NOTE: every always_comb target gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    ch_start_d   = ch_start_q;
    ch_end_d     = ch_end_q;
    row_d        = row_q;
    col_d        = col_q;
    cfg_err_d    = cfg_err_q;
    ch_d         = ch_q;
    r_d          = r_q;
    c_d          = c_q;
    bram_we_d    = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;

    if (start_accept) begin
      ch_start_d = i_channel_start;
      ch_end_d   = i_channel_end;
      row_d      = i_row;
      col_d      = i_col;
      cfg_err_d  = cfg_bad;
      ch_d       = i_channel_start;
      r_d        = '0;
      c_d        = '0;
    end else if (beat_accept) begin
      bram_we_d[map_bank] = 1'b1;
      bram_addr_d         = map_addr;
      bram_wdata_d        = i_data;
      // Raster advance: channel fastest, then column, then row.
      if (ch_wrap) begin
        ch_d = ch_start_q;
        if (c_wrap) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_start_q   <= '0;
      ch_end_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cfg_err_q    <= 1'b0;
      ch_q         <= '0;
      r_q          <= '0;
      c_q          <= '0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      ch_start_q   <= ch_start_d;
      ch_end_q     <= ch_end_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cfg_err_q    <= cfg_err_d;
      ch_q         <= ch_d;
      r_q          <= r_d;
      c_q          <= c_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign o_bram_we    = bram_we_q;
  assign o_bram_addr  = bram_addr_q;
  assign o_bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_output_writeback_scheduler.sv
// Randomized bench for output_writeback_scheduler against a raster-order
// write-list model built with nested loops and div/mod arithmetic.
module tb_output_writeback_scheduler;

  localparam int CW     = 8;
  localparam int RW     = 6;
  localparam int COLW   = 6;
  localparam int NUM    = 4;
  localparam int DEPTH  = 1152;
  localparam int AW     = $clog2(DEPTH);
  localparam int DW     = 16;
  localparam int BUDGET = 2000;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_start;
  logic [CW-1:0]   i_channel_start;
  logic [CW-1:0]   i_channel_end;
  logic [RW-1:0]   i_row;
  logic [COLW-1:0] i_col;
  logic            i_data_valid;
  logic [DW-1:0]   i_data;
  logic            o_data_ready;
  logic [NUM-1:0]  o_bram_we;
  logic [AW-1:0]   o_bram_addr;
  logic [DW-1:0]   o_bram_wdata;
  logic            o_busy;
  logic            o_done;
  logic            o_cfg_err;

  output_writeback_scheduler #(
    .OUTPUT_CHANNEL_WIDTH      (CW),
    .OUTPUT_ROW_WIDTH          (RW),
    .OUTPUT_COL_WIDTH          (COLW),
    .OUTPUT_BRAM_NUM           (NUM),
    .OUTPUT_BRAM_DEPTH         (DEPTH),
    .OUTPUT_BRAM_ADDRESS_WIDTH (AW),
    .DATA_WIDTH                (DW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_channel_start (i_channel_start),
    .i_channel_end   (i_channel_end),
    .i_row           (i_row),
    .i_col           (i_col),
    .i_data_valid    (i_data_valid),
    .i_data          (i_data),
    .o_data_ready    (o_data_ready),
    .o_bram_we       (o_bram_we),
    .o_bram_addr     (o_bram_addr),
    .o_bram_wdata    (o_bram_wdata),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_cfg_err       (o_cfg_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int bank;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec;
  int  n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected write list in stream order: row outer, column, channel inner.
  task automatic build_model(input int cs, input int ce, input int row, input int col);
    wr_t w;
    exp_q.delete();
    for (int r = 0; r < row; r++)
      for (int c = 0; c < col; c++)
        for (int ch = cs; ch <= ce; ch++) begin
          int d;
          d      = ch - cs;
          w.bank = d % NUM;
          w.addr = ((d / NUM) * row * col + r * col + c) % (1 << AW);
          w.data = 0;
          exp_q.push_back(w);
        end
  endtask

  task automatic drive_cfg(input int cs, input int ce, input int row, input int col);
    i_channel_start = CW'(cs);
    i_channel_end   = CW'(ce);
    i_row           = RW'(row);
    i_col           = COLW'(col);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(o_bram_we),    0);
    check({tag, "_addr"},  32'(o_bram_addr),  0);
    check({tag, "_wdata"}, 32'(o_bram_wdata), 0);
    check({tag, "_ready"}, 32'(o_data_ready), 0);
    check({tag, "_busy"},  32'(o_busy),       0);
    check({tag, "_done"},  32'(o_done),       0);
    check({tag, "_err"},   32'(o_cfg_err),    0);
  endtask

  // One valid tile. inject_at>0 pulses a conflicting start in that cycle;
  // rst_at>0 pulls reset right after that many beats were accepted.
  task automatic run_tile(input int cs, input int ce, input int row, input int col,
                          input int valid_pct, input int inject_at, input int rst_at);
    int  left, fin, acc, dut_writes, total;
    bit  pend, finished;
    wr_t pw;
    build_model(cs, ce, row, col);
    total      = exp_q.size();
    left       = total;
    fin        = -1;
    acc        = 0;
    dut_writes = 0;
    pend       = 1'b0;
    finished   = 1'b0;

    @(posedge i_clk); #1;
    i_start      = 1'b1;
    drive_cfg(cs, ce, row, col);
    i_data_valid = 1'b1;
    i_data       = DW'($urandom);
    @(negedge i_clk);
    check("start_ready", 32'(o_data_ready), 0);
    check("start_busy",  32'(o_busy),       0);

    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge i_clk); #1;
      i_start = (k == inject_at);
      if (k == inject_at) drive_cfg(1, 2, 1, 1);
      i_data_valid = ($urandom_range(99) < valid_pct);
      i_data       = DW'($urandom);
      @(negedge i_clk);

      if (o_bram_we != '0) dut_writes++;
      if (pend) begin
        check("we",    32'(o_bram_we),    32'(1) << pw.bank);
        check("addr",  32'(o_bram_addr),  32'(pw.addr));
        check("wdata", 32'(o_bram_wdata), 32'(pw.data));
      end else begin
        check("we_idle", 32'(o_bram_we), 0);
      end
      check("ready",   32'(o_data_ready), 32'(left > 0));
      check("done",    32'(o_done),       32'(fin >= 0 && k == fin + 2));
      check("busy",    32'(o_busy),       32'(!(fin >= 0 && k == fin + 3)));
      check("cfg_err", 32'(o_cfg_err),    0);

      pend = 1'b0;
      if (left > 0 && i_data_valid) begin
        pw      = exp_q.pop_front();
        pw.data = int'(i_data);
        pend    = 1'b1;
        left--;
        acc++;
        if (left == 0) fin = k;
      end

      if (rst_at > 0 && acc == rst_at) begin
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        i_start      = 1'b0;
        i_data_valid = 1'b0;
        @(negedge i_clk); #2;
        i_rst_n = 1'b1;
        return;
      end

      if (fin >= 0 && k == fin + 3) begin
        finished = 1'b1;
        break;
      end
    end

    check("tile_finished", 32'(finished), 1);
    check("write_count", 32'(dut_writes), 32'(total));
    i_start      = 1'b0;
    i_data_valid = 1'b0;
  endtask

  task automatic run_bad(input int cs, input int ce, input int row, input int col);
    int seen, dut_writes;
    seen       = 0;
    dut_writes = 0;
    @(posedge i_clk); #1;
    i_start      = 1'b1;
    drive_cfg(cs, ce, row, col);
    i_data_valid = 1'b1;
    @(negedge i_clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge i_clk); #1;
      i_start      = 1'b0;
      i_data_valid = 1'b1;
      i_data       = DW'($urandom);
      @(negedge i_clk);
      if (o_bram_we != '0) dut_writes++;
      check("bad_ready", 32'(o_data_ready), 0);
      if (o_done) begin
        seen++;
        check("bad_cfg_err", 32'(o_cfg_err), 1);
        check("bad_done_latency", 32'(k <= 2), 1);
      end
    end
    check("bad_done_count", 32'(seen), 1);
    check("bad_writes", 32'(dut_writes), 0);
    i_data_valid = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    drive_cfg(0, 0, 0, 0);
    #3;
    check_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk); #2;
    i_rst_n = 1'b1;

    run_tile(0, 7, 2, 3, 100, 0, 0);
    run_tile(0, 7, 2, 3, 60, 0, 0);
    run_tile(4, 5, 1, 1, 100, 0, 0);
    run_bad(5, 3, 2, 2);
    run_bad(0, 3, 0, 2);
    run_bad(0, 3, 2, 0);
    run_tile(0, 7, 2, 3, 100, 0, 10);
    run_tile(0, 7, 2, 3, 100, 0, 0);
    run_tile(0, 7, 2, 3, 100, 5, 0);
    run_tile(9, 9, 1, 1, 70, 0, 0);
    for (int t = 0; t < 6; t++) begin
      int cs;
      cs = int'($urandom_range(0, 20));
      run_tile(cs, cs + int'($urandom_range(0, 9)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)), int'($urandom_range(40, 100)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
